// File: rtl/sw_cond.sv
// ---------------------------------------------------------------------------
// sw_cond -- four-channel player-button conditioner.
//
// Each raw button bit is brought into the clk domain through a two-flop
// synchronizer. It is then debounced by a per-bit counter: a new level is
// accepted only after it has differed from the current debounced level for
// DEBOUNCE_CYCLES consecutive cycles. Debounced 0->1 transitions produce a
// one-cycle rise pulse, and any_press summarises those pulses.
//
// Parameters
//   DEBOUNCE_CYCLES : stable cycles needed to accept a new level (2..65535)
//   CNT_W           : debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports
//   clk       in   single clock, rising-edge
//   rst       in   synchronous active-high reset
//   raw_sw    in   [3:0] asynchronous, bouncing buttons (active-high)
//   switches  out  [3:0] registered debounced levels
//   sw_rise   out  [3:0] registered one-cycle pulse on each debounced 0->1
//   any_press out  registered, high exactly when sw_rise is nonzero
// ---------------------------------------------------------------------------
module sw_cond #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_sw,
    output logic [3:0] switches,
    output logic [3:0] sw_rise,
    output logic       any_press
);

    // Final count value; the edge that finds a counter here accepts the level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [3:0]       s1;
    logic [3:0]       s2;
    logic [CNT_W-1:0] cnt      [4];
    logic [CNT_W-1:0] cnt_next [4];
    logic [3:0]       accept;
    logic [3:0]       sw_next;
    logic [3:0]       rise_next;

    // Debounce decision, one independent lane per bit. Only synchronized
    // (s2) and registered values feed this logic, so no combinational path
    // exists from raw_sw to any output.
    always_comb begin
        accept    = '0;
        cnt_next  = '{default: '0};
        for (int i = 0; i < 4; i++) begin
            accept[i] = (s2[i] != switches[i]) && (cnt[i] == CNT_LAST);
            // Agreement or acceptance clears the counter, so it never passes
            // CNT_LAST and cannot wrap; a short glitch also lands back at 0.
            if ((s2[i] == switches[i]) || accept[i]) begin
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_ONE;
            end
        end
        sw_next   = (switches & ~accept) | (s2 & accept);
        // An accepted bit always flips, so accept & s2 marks exactly 0->1.
        rise_next = accept & s2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1        <= '0;
            s2        <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= '0;
            end
            switches  <= '0;
            sw_rise   <= '0;
            any_press <= 1'b0;
        end else begin
            // Synchronizer stages
            s1        <= raw_sw;
            s2        <= s1;
            // Debounce counters and registered outputs
            for (int i = 0; i < 4; i++) begin
                cnt[i] <= cnt_next[i];
            end
            switches  <= sw_next;
            sw_rise   <= rise_next;
            any_press <= |rise_next;
        end
    end

endmodule

// File: tb/tb_sw_cond.sv
// ---------------------------------------------------------------------------
// tb_sw_cond -- self-checking bench for sw_cond with DEBOUNCE_CYCLES = 4.
// Directed steps push the expected output change (edge number, level, rise
// pulse) into a scoreboard queue; every cycle the outputs are compared with
// the expected state, which is updated as scheduled entries come due.
// ---------------------------------------------------------------------------
module tb_sw_cond;

    localparam int DEB = 4;
    // A level stable before edge k appears on edge k+DEB+1. Stimulus is
    // driven after edge n has been checked, so k = n+1 and the change lands
    // on edge n+DEB+2.
    localparam int LAT = DEB + 2;

    logic       clk;
    logic       rst;
    logic [3:0] raw_sw;
    logic [3:0] switches;
    logic [3:0] sw_rise;
    logic       any_press;

    sw_cond #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .raw_sw   (raw_sw),
        .switches (switches),
        .sw_rise  (sw_rise),
        .any_press(any_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         edge_no;
        logic [3:0] sw;
        logic [3:0] rise;
    } ev_t;

    ev_t        sb[$];
    int         edge_n;
    int         checks;
    int         errors;
    logic [3:0] exp_sw;
    logic [3:0] exp_rise;

    task automatic expect_ev(input int e, input logic [3:0] sw, input logic [3:0] rise);
        ev_t ev;
        ev.edge_no = e;
        ev.sw      = sw;
        ev.rise    = rise;
        sb.push_back(ev);
    endtask

    // One clock: advance past the rising edge, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        exp_rise = 4'b0000;
        while (sb.size() > 0 && sb[0].edge_no <= edge_n) begin
            checks++;
            assert (sb[0].edge_no == edge_n)
            else begin
                errors++;
                $error("FAIL sb_due edge=%0d scheduled=%0d", edge_n, sb[0].edge_no);
            end
            exp_sw   = sb[0].sw;
            exp_rise = sb[0].rise;
            void'(sb.pop_front());
        end
        checks++;
        assert (switches === exp_sw)
        else begin
            errors++;
            $error("FAIL switches edge=%0d got=%b exp=%b", edge_n, switches, exp_sw);
        end
        checks++;
        assert (sw_rise === exp_rise)
        else begin
            errors++;
            $error("FAIL sw_rise edge=%0d got=%b exp=%b", edge_n, sw_rise, exp_rise);
        end
        checks++;
        assert (any_press === (exp_rise != 4'b0000))
        else begin
            errors++;
            $error("FAIL any_press edge=%0d got=%b exp=%b", edge_n, any_press,
                   (exp_rise != 4'b0000));
        end
    endtask

    initial begin
        edge_n   = 0;
        checks   = 0;
        errors   = 0;
        exp_sw   = 4'b0000;
        exp_rise = 4'b0000;
        rst      = 1'b1;
        raw_sw   = 4'b0000;

        // Reset state
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Case 1: single bit press
        raw_sw = 4'b0010;
        expect_ev(edge_n + LAT, 4'b0010, 4'b0010);
        repeat (10) tick();

        // Case 2: two-cycle glitch on bit 0 is rejected
        raw_sw = 4'b0011;
        repeat (2) tick();
        raw_sw = 4'b0010;
        repeat (8) tick();

        // Case 4: release of bit 1 falls with no pulse
        raw_sw = 4'b0000;
        expect_ev(edge_n + LAT, 4'b0000, 4'b0000);
        repeat (10) tick();

        // Case 3: two bits on the same edge
        raw_sw = 4'b1001;
        expect_ev(edge_n + LAT, 4'b1001, 4'b1001);
        repeat (10) tick();
        raw_sw = 4'b0000;
        expect_ev(edge_n + LAT, 4'b0000, 4'b0000);
        repeat (10) tick();

        // Case 5: one-cycle reset three cycles into a debounce
        raw_sw = 4'b0100;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_ev(edge_n + LAT, 4'b0100, 4'b0100);
        repeat (10) tick();
        raw_sw = 4'b0000;
        expect_ev(edge_n + LAT, 4'b0000, 4'b0000);
        repeat (10) tick();

        // Case 6: all buttons held through reset count as a new press
        raw_sw = 4'b1111;
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        expect_ev(edge_n + LAT, 4'b1111, 4'b1111);
        repeat (10) tick();

        checks++;
        assert (sb.size() == 0)
        else begin
            errors++;
            $error("FAIL sb_drained left=%0d exp=0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_cond.md
SW_COND -- requirements
Module: sw_cond

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive stable cycles required to accept a new switch level; legal range is 2 to 65535.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 The module SHALL have port raw_sw, input, 4 bits: asynchronous, bouncing player buttons, one bit per player, active-high.
REQ-006 The module SHALL have port switches, output, 4 bits: the registered, debounced switch levels, feeding the first/second capture stage directly.
REQ-007 The module SHALL have port sw_rise, output, 4 bits: a registered one-cycle pulse per bit on each debounced 0->1 transition.
REQ-008 The module SHALL have port any_press, output, 1 bit: registered; asserted in exactly the cycles where sw_rise is nonzero.

Function
REQ-009 Each raw_sw bit SHALL pass through a two-flop synchronizer (s1, then s2) before any other logic uses it.
REQ-010 Each bit SHALL have an independent counter cnt[i] of CNT_W bits, handled per cycle as follows:
- s2[i] == switches[i]: cnt[i] <= 0.
- s2[i] != switches[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
- s2[i] != switches[i] and cnt[i] == DEBOUNCE_CYCLES-1: switches[i] <= s2[i] and cnt[i] <= 0.
REQ-011 Latency: if raw_sw[i] holds a new value stable from before edge k, switches[i] SHALL take that value on edge k+DEBOUNCE_CYCLES+1 and not earlier.
REQ-012 A raw pulse or glitch on bit i whose synchronized length is shorter than DEBOUNCE_CYCLES cycles SHALL leave switches[i] unchanged and SHALL return cnt[i] to 0.
REQ-013 On the edge where switches[i] changes 0->1, sw_rise[i] SHALL be set to 1; on every other edge sw_rise[i] SHALL be 0, so the pulse lasts exactly one cycle, coincident with the first cycle switches[i] reads 1.
REQ-014 Debounced 1->0 transitions SHALL produce no pulse on any output.
REQ-015 Bits SHALL be fully independent: several bits qualifying on the same edge SHALL update together and pulse together in that one cycle, with any_press high for a single cycle.
REQ-016 Counters SHALL saturate by construction (cleared on acceptance) and SHALL never wrap.
REQ-017 The module SHALL contain no latches, no combinational path from raw_sw to any output, and no gated or derived clocks.

Reset
REQ-018 While rst=1 at a clock edge, s1, s2, cnt, switches, sw_rise and any_press SHALL all be cleared to 0.
REQ-019 If raw_sw is high during reset, after release the module SHALL treat it as a new press: it SHALL be debounced per REQ-011, then produce a sw_rise pulse.
REQ-020 Reset asserted mid-debounce SHALL discard the partial count; the count restarts from 0 after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-021 Case 1: raw_sw=4'b0010 stable from edge k -> switches=4'b0010 after edge k+5; sw_rise=4'b0010 and any_press=1 for that one cycle only.
REQ-022 Case 2: raw_sw[0] high for 2 cycles, then low -> switches, sw_rise and any_press stay 0 throughout; cnt[0] returns to 0.
REQ-023 Case 3: raw_sw=4'b1001 changes on a single edge -> both bits update on the same edge; sw_rise=4'b1001; any_press high for one cycle.
REQ-024 Case 4: bit held high and then released -> switches[i] falls 5 edges after release with no sw_rise pulse.
REQ-025 Case 5: rst pulsed for 1 cycle, 3 cycles into a debounce of 4'b0100 -> all outputs 0; switches=4'b0100 only after a full 5 edges following release.
REQ-026 Case 6: raw_sw=4'b1111 held through reset -> 5 edges after release, switches=4'b1111 and sw_rise=4'b1111 for one cycle.
